// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: widths, opcodes and FSM states.
package alu_ctrl_pkg;

  localparam int W_DEF   = 16;
  localparam int OPW_DEF = 3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_NOT   = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_PASSB = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time gets it.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  assign gnt0_o = valid0_i & (~valid1_i | last_grant_i);
  assign gnt1_o = valid1_i & (~valid0_i | ~last_grant_i);

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external 16-bit ALU between two requesters, one operation in flight,
// with operands held until the ALU's registered zero flag has settled.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  input  logic           rsp0_ready,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp_out,
  output logic           rsp_zf,
  output logic [OPW-1:0] alu_sel,
  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zf,
  output logic           busy
);

  state_t         state_q;
  logic           last_grant_q;
  logic           owner_q;
  logic [OPW-1:0] sel_q;
  logic [W-1:0]   in1_q;
  logic [W-1:0]   in2_q;
  logic [W-1:0]   out_q;
  logic           zf_q;
  logic           gnt0;
  logic           gnt1;
  logic           in_idle;
  logic           owner_ready;

  rr_arb2 u_rr_arb2 (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1)
  );

  // Ready is suppressed while reset is asserted, even though the state is combinationally IDLE.
  assign in_idle     = (state_q == ST_IDLE);
  assign req0_ready  = rst & in_idle & gnt0;
  assign req1_ready  = rst & in_idle & gnt1;
  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      sel_q        <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      out_q        <= '0;
      zf_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0_ready || req1_ready) begin
            state_q      <= ST_ISSUE;
            owner_q      <= req1_ready;
            last_grant_q <= req1_ready;
            sel_q        <= req1_ready ? req1_op : req0_op;
            in1_q        <= req1_ready ? req1_a  : req0_a;
            in2_q        <= req1_ready ? req1_b  : req0_b;
          end
        end
        ST_ISSUE:  state_q <= ST_SETTLE;
        // The ALU's zero flag lags its result by one cycle; both are valid here.
        ST_SETTLE: begin
          state_q <= ST_RESP;
          out_q   <= alu_out;
          zf_q    <= alu_zf;
        end
        ST_RESP: begin
          if (owner_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp0_valid = (state_q == ST_RESP) & ~owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &  owner_q;
  assign rsp_out    = out_q;
  assign rsp_zf     = zf_q;
  assign alu_sel    = sel_q;
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign busy       = ~in_idle;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomised and directed bench for alu_req_arbiter against a transaction-level model.
module tb_alu_req_arbiter;
  import alu_ctrl_pkg::*;

  localparam int W   = 16;
  localparam int OPW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zf, busy;
  logic [W-1:0]   rsp_out, alu_in1, alu_in2, alu_out;
  logic [OPW-1:0] alu_sel;
  logic           alu_zf;

  bit             pend [2];
  logic [OPW-1:0] p_op [2];
  logic [W-1:0]   p_a  [2];
  logic [W-1:0]   p_b  [2];
  bit             rr   [2];

  alu_req_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(pend[0]), .req0_ready(req0_ready), .req0_op(p_op[0]), .req0_a(p_a[0]), .req0_b(p_b[0]),
    .req1_valid(pend[1]), .req1_ready(req1_ready), .req1_op(p_op[1]), .req1_a(p_a[1]), .req1_b(p_b[1]),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rr[0]), .rsp1_ready(rr[1]),
    .rsp_out(rsp_out), .rsp_zf(rsp_zf),
    .alu_sel(alu_sel), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_zf(alu_zf), .busy(busy)
  );

  function automatic logic [W-1:0] alu_ref(logic [OPW-1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_NOT:   return ~a;
      OP_XOR:   return a ^ b;
      OP_PASSB: return b;
      default:  return a + b;
    endcase
  endfunction

  // External ALU stand-in: combinational result, zero flag registered one cycle later.
  assign alu_out = alu_ref(alu_sel, alu_in1, alu_in2);
  always_ff @(posedge clk) begin
    if (!rst) alu_zf <= 1'b0;
    else      alu_zf <= (alu_out == '0);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: an op in flight, its age in cycles, and the captured response.
  bit             m_busy = 0;
  int             m_age = 0;
  int             m_owner = 0;
  bit             m_last = 1;
  bit             m_acc [2];
  logic [OPW-1:0] m_sel = '0;
  logic [W-1:0]   m_in1 = '0, m_in2 = '0, m_res = '0, m_out = '0;
  bit             m_zf = 0;
  int             cyc_n = 0;

  int             dacc_cyc [$];
  int             dacc_own [$];
  int             last_dacc_cyc = 0;
  bit             obs_seen, obs_hs, obs_other;
  logic [W-1:0]   obs_out;
  bit             obs_zf;
  int             obs_lat, obs_hs_cyc;

  function automatic int winner();
    if (pend[0] && pend[1]) return m_last ? 0 : 1;
    if (pend[0]) return 0;
    if (pend[1]) return 1;
    return -1;
  endfunction

  task automatic model_update();
    int w;
    m_acc[0] = 0;
    m_acc[1] = 0;
    if (!rst) begin
      m_busy = 0; m_last = 1; m_sel = '0; m_in1 = '0; m_in2 = '0; m_out = '0; m_zf = 0;
    end else if (!m_busy) begin
      w = winner();
      if (w >= 0) begin
        m_busy = 1; m_age = 0; m_owner = w; m_last = (w == 1); m_acc[w] = 1;
        m_sel = p_op[w]; m_in1 = p_a[w]; m_in2 = p_b[w];
        m_res = alu_ref(p_op[w], p_a[w], p_b[w]);
      end
    end else if (m_age < 2) begin
      m_age++;
      if (m_age == 2) begin
        m_out = m_res;
        m_zf  = (m_res == '0);
      end
    end else if (rr[m_owner]) begin
      m_busy = 0;
    end
  endtask

  // Entered at a falling edge with inputs driven; returns at the next falling edge.
  task automatic cyc();
    bit er0, er1, ev0, ev1;
    #1;
    er0 = rst && !m_busy && (winner() == 0);
    er1 = rst && !m_busy && (winner() == 1);
    ev0 = m_busy && (m_age == 2) && (m_owner == 0);
    ev1 = m_busy && (m_age == 2) && (m_owner == 1);
    check_eq("req0_ready", req0_ready, er0);
    check_eq("req1_ready", req1_ready, er1);
    check_eq("rsp0_valid", rsp0_valid, ev0);
    check_eq("rsp1_valid", rsp1_valid, ev1);
    check_eq("busy", busy, m_busy);
    check_eq("alu_sel", alu_sel, m_sel);
    check_eq("alu_in1", alu_in1, m_in1);
    check_eq("alu_in2", alu_in2, m_in2);
    check_eq("rsp_out", rsp_out, m_out);
    check_eq("rsp_zf", rsp_zf, m_zf);
    for (int r = 0; r < 2; r++) begin
      if ((r == 0) ? (pend[0] && req0_ready) : (pend[1] && req1_ready)) begin
        dacc_cyc.push_back(cyc_n + 1);
        dacc_own.push_back(r);
        last_dacc_cyc = cyc_n + 1;
      end
    end
    if ((rsp0_valid || rsp1_valid) && !obs_seen) begin
      obs_seen = 1;
      obs_out  = rsp_out;
      obs_zf   = rsp_zf;
      obs_lat  = cyc_n + 1 - last_dacc_cyc;
    end
    if ((rsp0_valid && rr[0]) || (rsp1_valid && rr[1])) begin
      obs_hs     = 1;
      obs_hs_cyc = cyc_n + 1;
    end
    @(posedge clk);
    cyc_n++;
    model_update();
    @(negedge clk);
    for (int r = 0; r < 2; r++) if (m_acc[r]) pend[r] = 0;
  endtask

  task automatic new_req(input int r);
    pend[r] = 1;
    p_op[r] = OPW'($urandom_range(0, 7));
    p_a[r]  = W'($urandom);
    p_b[r]  = ($urandom_range(0, 3) == 0) ? p_a[r] : W'($urandom);
  endtask

  task automatic run_op(input string tag, input int r, input logic [OPW-1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_out, input bit exp_zf);
    pend[r] = 1; p_op[r] = op; p_a[r] = a; p_b[r] = b;
    rr[0] = 1; rr[1] = 1;
    obs_seen = 0; obs_hs = 0; obs_other = 0;
    for (int i = 0; i < 20 && !obs_hs; i++) begin
      if ((r == 0 && rsp1_valid) || (r == 1 && rsp0_valid)) obs_other = 1;
      cyc();
    end
    check_eq({tag, "_done"}, obs_hs, 1);
    check_eq({tag, "_out"}, obs_out, exp_out);
    check_eq({tag, "_zf"}, obs_zf, exp_zf);
    check_eq({tag, "_latency"}, obs_lat, 3);
    check_eq({tag, "_other_rsp"}, obs_other, 0);
  endtask

  initial begin
    int base, n;
    logic [W-1:0] held_out;
    rst = 0;
    pend[0] = 1; pend[1] = 1;
    p_op[0] = OP_ADD; p_a[0] = 16'h1111; p_b[0] = 16'h2222;
    p_op[1] = OP_SUB; p_a[1] = 16'h3333; p_b[1] = 16'h4444;
    rr[0] = 1; rr[1] = 1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    // Held in reset with both requests pending: nothing may be accepted.
    repeat (3) cyc();
    pend[0] = 0; pend[1] = 0; rst = 1;
    repeat (2) cyc();

    run_op("add", 0, OP_ADD, 16'h0003, 16'h0005, 16'h0008, 0);
    run_op("sub_zero", 1, OP_SUB, 16'h1234, 16'h1234, 16'h0000, 1);
    run_op("passb", 1, OP_PASSB, 16'h1234, 16'h00FF, 16'h00FF, 0);
    run_op("op7", 0, 3'd7, 16'hFFFF, 16'h0001, 16'h0000, 1);

    // Both requesters always pending: grants must alternate, 4 cycles apart.
    base = dacc_cyc.size();
    new_req(0); new_req(1);
    repeat (26) begin
      cyc();
      for (int r = 0; r < 2; r++) if (!pend[r]) new_req(r);
    end
    n = dacc_cyc.size();
    check_eq("alt_count", (n - base) >= 6, 1);
    for (int i = base + 1; i < n; i++) begin
      check_eq("alt_gap", dacc_cyc[i] - dacc_cyc[i-1], 4);
      check_eq("alt_owner", dacc_own[i] != dacc_own[i-1], 1);
    end
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 10 && m_busy; i++) cyc();

    // Owner 0 stalls the response; requester 1 waits behind it.
    rr[0] = 0; rr[1] = 1;
    pend[0] = 1; p_op[0] = OP_OR; p_a[0] = 16'h0F00; p_b[0] = 16'h00F0;
    obs_seen = 0; obs_hs = 0;
    for (int i = 0; i < 10 && !obs_seen; i++) cyc();
    check_eq("hold_reached", obs_seen, 1);
    pend[1] = 1; p_op[1] = OP_AND; p_a[1] = 16'hFF00; p_b[1] = 16'h0FF0;
    held_out = rsp_out;
    check_eq("hold_value", held_out, 16'h0FF0);
    repeat (5) begin
      cyc();
      check_eq("hold_out", rsp_out, held_out);
      check_eq("hold_req1_ready", req1_ready, 0);
    end
    rr[0] = 1;
    for (int i = 0; i < 4 && !obs_hs; i++) cyc();
    check_eq("hold_hs", obs_hs, 1);
    cyc();
    check_eq("hold_req1_accept", last_dacc_cyc, obs_hs_cyc + 1);
    for (int i = 0; i < 10 && m_busy; i++) cyc();

    // Reset during SETTLE aborts the op with no response.
    pend[0] = 1; p_op[0] = OP_ADD; p_a[0] = 16'h0001; p_b[0] = 16'h0001;
    for (int i = 0; i < 10 && !(m_busy && m_age == 1); i++) cyc();
    check_eq("settle_reached", m_busy && m_age == 1, 1);
    rst = 0;
    cyc();
    rst = 1;
    repeat (4) begin
      #1;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_rsp0", rsp0_valid, 0);
      cyc();
    end
    run_op("xor", 0, OP_XOR, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0);

    // Randomised traffic with occasional mid-flight resets.
    repeat (1500) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) new_req(r);
        rr[r] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

- Shares the single 16-bit ALU (`alu16b`) between two requesters.
- Arbitrates round-robin, drives the ALU operand and select ports, and holds them stable until the registered zero flag has settled.
- Returns the result and zero flag to the winning requester over a valid/ready handshake.
- Sits between the ALU and the two datapath clients: one operation in flight, no queuing.

## Interface
Parameters:
- `W`, 16, operand/result width (must match ALU width)
- `OPW`, 3, opcode width (ALU `sel`)

Ports (reset: synchronous, active-low):
- `clk`  input  1  single clock, all state updates on rising edge
- `rst`  input  1  synchronous, active-low reset
- `req0_valid`  input  1  requester 0 has an op
- `req0_ready`  output  1  arbiter accepts requester 0 op this cycle
- `req0_op`  input  OPW  ALU select for requester 0
- `req0_a`, `req0_b`  input  W each  operands for requester 0
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`  same roles for requester 1
- `rsp0_valid`, `rsp1_valid`  output  1 each  result available for that requester
- `rsp0_ready`, `rsp1_ready`  input  1 each  requester takes result
- `rsp_out`  output  W  captured ALU result (shared by both response channels)
- `rsp_zf`  output  1  captured ALU zero flag
- `alu_sel`  output  OPW  to ALU `sel`
- `alu_in1`, `alu_in2`  output  W each  to ALU `in1`/`in2`
- `alu_out`  input  W  from ALU `out` (combinational in ALU)
- `alu_zf`  input  1  from ALU `zf` (registered in ALU, one cycle behind `out`)
- `busy`  output  1  state ≠ IDLE

## Operation
- States and transitions:
  - IDLE → ISSUE on accepted request.
  - ISSUE → SETTLE unconditionally.
  - SETTLE → RESP unconditionally.
  - RESP → IDLE on handshake by the owner (`rspN_valid && rspN_ready`).
- `reqN_ready` is asserted only in IDLE, only for the current grant. It is combinational from the valids and `last_grant`.
- Grant rule in IDLE:
  - Only one valid: that requester wins.
  - Both valid: the requester ≠ `last_grant` wins.
  - `last_grant` updates on acceptance only.
- On acceptance:
  - Latch op into `alu_sel`, a into `alu_in1`, b into `alu_in2`, and record the owner.
  - These outputs are held unchanged through ISSUE and SETTLE.
- At the SETTLE→RESP edge, capture `rsp_out` ← `alu_out` and `rsp_zf` ← `alu_zf`.
- RESP:
  - `rspN_valid` = 1 for the owner only.
  - `rsp_out`/`rsp_zf` are stable until the handshake.
  - Other requesters wait and see `req_ready` = 0.
- Opcodes 0–6 are passed unchanged; opcode 7 is passed too and the ALU treats it as ADD. The arbiter does no op decode.
- Requests are not dropped: a valid request that is not ready stays pending. Requester inputs are sampled only on the acceptance cycle.

## Timing
- Reset (`rst`=0 at a rising edge) forces the following values:
  - state = IDLE
  - `last_grant` = 1, so requester 0 wins the first tie
  - `alu_sel`/`alu_in1`/`alu_in2` = 0
  - `rsp_out` = 0, `rsp_zf` = 0
  - all `rsp*_valid` = 0, `busy` = 0
  - `req*_ready` = 0 while `rst` = 0
- Reset mid-operation aborts the op; no response is ever produced for it.
- Latency: acceptance at edge E0 → `rspN_valid` high from E3 (3 cycles).
  - ISSUE spans E0–E1: the ALU `out` is valid and the ALU registers `zf` at E1.
  - SETTLE spans E1–E2: `zf` is valid.
  - Capture happens at E2; response is visible from E3 per the state sequence.
- Minimum occupancy is 4 cycles per op (IDLE accept + ISSUE + SETTLE + RESP with immediate ready). Peak throughput is 1 op / 4 cycles.
- Response handshake in RESP with `rspN_ready` already high: completes on the first RESP edge, and a new request can be accepted in the following IDLE cycle.
- `rsp_ready` from the non-owner is ignored.

## Structure
- Shared package `alu_ctrl_pkg`:
  - opcode constants: `OP_ADD`=0, `OP_SUB`=1, `OP_AND`=2, `OP_OR`=3, `OP_NOT`=4, `OP_XOR`=5, `OP_PASSB`=6
  - state encoding: IDLE, ISSUE, SETTLE, RESP
  - `W`/`OPW` defaults
- One sub-module, `rr_arb2`: a 2-way round-robin grant from (`valid0`, `valid1`, `last_grant`), combinational.
- The ALU is not instantiated inside this block; the parent wires it to the `alu_*` ports on the same `clk`/`rst`.

## Test plan
- Reset then idle → all outputs 0, `busy`=0, no ready while `rst`=0.
- req0 ADD a=16'h0003 b=16'h0005, `rsp0_ready`=1 → `rsp0_valid` 3 cycles after accept, `rsp_out`=16'h0008, `rsp_zf`=0, `rsp1_valid` stays 0.
- req1 SUB a=16'h1234 b=16'h1234 → `rsp_out`=0, `rsp_zf`=1. Then req1 PASSB b=16'h00FF → `rsp_zf`=0 (zero flag not stale).
- Both valid continuously, `rsp_ready`=1 → grants alternate 0,1,0,1, each op exactly 4 cycles apart.
- `rsp0_ready` held 0 for 5 cycles in RESP → `rsp_out`/`rsp_zf` stable, `req1_ready`=0 throughout, and req1 is accepted the cycle after the handshake.
- Assert `rst`=0 during SETTLE → next cycle IDLE, no `rsp*_valid`. A following req0 XOR 16'hFFFF, 16'h0F0F → `rsp_out`=16'hF0F0.
